apb_master_arbiter: RTL

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration in front of a single
// IDLE/SETUP/ACCESS transfer engine with a bounded PREADY wait.
module apb_master_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ack,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [7:0]  PWDATA,
  input  logic [7:0]  PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwrite_q, pwrite_d;
  logic [7:0]       paddr_q, paddr_d;
  logic [7:0]       pwdata_q, pwdata_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic grant_idx;
  logic start;

  // With both requesters pending the pointer decides; a lone requester wins outright.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_idx = ptr_q;
    if (req_valid == 2'b01) begin
      grant_idx = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant_idx = 1'b1;
    end
  end

  assign start   = (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign req_ack = (start && PRESETn) ? (2'b01 << grant_idx) : 2'b00;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          gnt_d    = grant_idx;
          ptr_d    = ~grant_idx;
          pwrite_d = req_write[grant_idx];
          paddr_d  = grant_idx ? req_addr[15:8]  : req_addr[7:0];
          pwdata_d = grant_idx ? req_wdata[15:8] : req_wdata[7:0];
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        // A ready slave wins even on the cycle the wait budget runs out.
        if (PREADY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b01 << gnt_q;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? 8'h00 : PRDATA;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b01 << gnt_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 8'h00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: a synchronous reset clears every register here, including the data
    // registers, because the APB data outputs must read zero out of reset.
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
